xor_train_scheduler: RTL
========================

XOR_TRAIN_SCHEDULER -- requirements
Module: xor_train_scheduler

Interface
REQ-001 SHALL have parameter DW, default 16, sample/target width (8.8 fixed point).
REQ-002 SHALL have parameter TIMEOUT, default 1024, max cycles to wait for nn_done per sample.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have port cfg_we  input  1  sample-table write strobe.
REQ-006 SHALL have port cfg_addr  input  2  table entry index 0..3.
REQ-007 SHALL have ports cfg_x1, cfg_x2, cfg_target  input  DW each  signed entry data.
REQ-008 SHALL have port cfg_num_samples  input  3  samples per epoch, valid 1..4.
REQ-009 SHALL have port cfg_max_epochs  input  16  epochs to run, valid 1..65535.
REQ-010 SHALL have ports run, abort  input  1 each  single-cycle command pulses.
REQ-011 SHALL have port nn_start  output  1  one-cycle start to training core.
REQ-012 SHALL have ports nn_x1, nn_x2, nn_target  output  DW each  sample to core.
REQ-013 SHALL have port nn_done  input  1  pulse from core: sample update complete.
REQ-014 SHALL have ports busy, done, err  output  1 each  status.
REQ-015 SHALL have ports epoch_cnt  output  16, sample_idx  output  2  progress.

Function
REQ-016 SHALL hold a 4-entry table {x1,x2,target}; reset contents (0,0,0),(0,256,256),(256,0,256),(256,256,0).
REQ-017 SHALL write entry cfg_addr on cfg_we only when busy=0; writes while busy are ignored.
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT, NEXT, FINISH.
REQ-019 IDLE: on run, latch cfg_num_samples/cfg_max_epochs, clear sample_idx, epoch_cnt, err; go ISSUE.
REQ-020 IDLE: run with cfg_num_samples outside 1..4 or cfg_max_epochs=0 SHALL go FINISH with err=1, no nn_start.
REQ-021 ISSUE: nn_start=1 for exactly that cycle; nn_x1/x2/target = table[sample_idx]; clear watchdog; go WAIT.
REQ-022 nn_x1/nn_x2/nn_target SHALL remain stable from ISSUE until the next ISSUE.
REQ-023 WAIT: nn_done=1 goes NEXT; watchdog reaching TIMEOUT-1 without nn_done goes FINISH with err=1.
REQ-024 NEXT: if sample_idx<num-1, increment sample_idx, go ISSUE.
REQ-025 NEXT: else sample_idx=0, epoch_cnt+1; if new epoch_cnt==max go FINISH, else ISSUE.
REQ-026 FINISH: done=1 for exactly one cycle; go IDLE; err holds until next accepted run.
REQ-027 abort in ISSUE/WAIT/NEXT SHALL go FINISH with err=0, epoch_cnt frozen; abort wins over simultaneous nn_done.
REQ-028 run while busy=1 and abort in IDLE/FINISH SHALL be ignored.
REQ-029 nn_done outside WAIT SHALL be ignored.
REQ-030 busy SHALL be 1 in ISSUE, WAIT, NEXT, FINISH; 0 in IDLE.
REQ-031 Latency: run sampled at edge N -> nn_start high cycle N+1; nn_done at edge M -> next nn_start cycle M+2.

Reset
REQ-032 rst=0 at any edge, including mid-run, SHALL force IDLE, table to REQ-016 values, and nn_start, done, err, busy to 0.
REQ-033 SHALL clear epoch_cnt, sample_idx, nn_x1, nn_x2, nn_target and the watchdog on reset.

Verification
REQ-034 SHALL cover num=4, max=3, core returns nn_done 5 cycles after each nn_start -> 12 nn_start pulses in order idx 0,1,2,3 repeated, done pulse, epoch_cnt=3, err=0.
REQ-035 SHALL cover cfg_we addr 1 = (256,256,0) then run num=2, max=1 -> second issued sample is (256,256,0).
REQ-036 SHALL cover core never asserting nn_done -> done with err=1 exactly TIMEOUT cycles after WAIT entry, epoch_cnt=0.
REQ-037 SHALL cover abort and nn_done in the same cycle during epoch 1 -> done, err=0, epoch_cnt=1, no further nn_start.
REQ-038 SHALL cover run with num=0 -> done pulse next cycle, err=1, no nn_start; and run with max=0 -> same.
REQ-039 SHALL cover rst=0 during WAIT -> next cycle busy=0, nn_start=0, table back to reset XOR contents.

Source files
------------

// File: rtl/xor_train_scheduler.sv
// xor_train_scheduler: sequences the four XOR training samples into a
// training core, one sample at a time, for a configured number of epochs.
// Core handshake: nn_start is a one-cycle pulse that presents a sample on
// nn_x1/nn_x2/nn_target, and the sample stays put until the next nn_start.
// The core answers with a one-cycle nn_done pulse. nn_done is only heeded in
// WAIT, and abort always takes priority over nn_done.
module xor_train_scheduler #(
  parameter int DW      = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [1:0]           cfg_addr,
  input  logic signed [DW-1:0] cfg_x1,
  input  logic signed [DW-1:0] cfg_x2,
  input  logic signed [DW-1:0] cfg_target,
  input  logic [2:0]           cfg_num_samples,
  input  logic [15:0]          cfg_max_epochs,
  input  logic                 run,
  input  logic                 abort,
  output logic                 nn_start,
  output logic signed [DW-1:0] nn_x1,
  output logic signed [DW-1:0] nn_x2,
  output logic signed [DW-1:0] nn_target,
  input  logic                 nn_done,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [15:0]          epoch_cnt,
  output logic [1:0]           sample_idx,
  output logic [2:0]           state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_NEXT   = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  // 1.0 in 8.8 fixed point
  localparam logic signed [DW-1:0] ONE = DW'(256);

  state_t state, state_d;

  logic signed [DW-1:0] tbl_x1 [4];
  logic signed [DW-1:0] tbl_x2 [4];
  logic signed [DW-1:0] tbl_t  [4];

  logic [2:0]      num_q;
  logic [15:0]     max_q;
  logic [WD_W-1:0] wd;

  logic [1:0]  idx_d;
  logic [15:0] epoch_d;
  logic [15:0] epoch_inc;
  logic        err_d;
  logic        latch_cfg;
  logic        cfg_bad;

  assign epoch_inc = epoch_cnt + 16'd1;
  assign cfg_bad   = (cfg_num_samples == 3'd0) || (cfg_num_samples > 3'd4) ||
                     (cfg_max_epochs == 16'd0);

  // Moore outputs decoded straight from the state register
  assign nn_start  = (state == S_ISSUE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_FINISH);
  assign state_dbg = state;

  // Next-state and progress-counter decisions
  always_comb begin
    state_d   = state;
    idx_d     = sample_idx;
    epoch_d   = epoch_cnt;
    err_d     = err;
    latch_cfg = 1'b0;
    case (state)
      S_IDLE: begin
        if (run) begin
          latch_cfg = 1'b1;
          idx_d     = 2'd0;
          epoch_d   = 16'd0;
          err_d     = 1'b0;
          if (cfg_bad) begin
            err_d   = 1'b1;
            state_d = S_FINISH;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        state_d = abort ? S_FINISH : S_WAIT;
      end
      S_WAIT: begin
        if (abort) begin
          state_d = S_FINISH;
        end else if (nn_done) begin
          state_d = S_NEXT;
        end else if (wd == WD_LAST) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end
      end
      S_NEXT: begin
        if (abort) begin
          state_d = S_FINISH;
        end else if ({1'b0, sample_idx} < (num_q - 3'd1)) begin
          idx_d   = sample_idx + 2'd1;
          state_d = S_ISSUE;
        end else begin
          idx_d   = 2'd0;
          epoch_d = epoch_inc;
          state_d = (epoch_inc == max_q) ? S_FINISH : S_ISSUE;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, progress, watchdog and presented-sample registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      sample_idx <= 2'd0;
      epoch_cnt  <= 16'd0;
      err        <= 1'b0;
      num_q      <= 3'd0;
      max_q      <= 16'd0;
      wd         <= '0;
      nn_x1      <= '0;
      nn_x2      <= '0;
      nn_target  <= '0;
    end else begin
      state      <= state_d;
      sample_idx <= idx_d;
      epoch_cnt  <= epoch_d;
      err        <= err_d;
      if (latch_cfg) begin
        num_q <= cfg_num_samples;
        max_q <= cfg_max_epochs;
      end
      if (state == S_ISSUE) begin
        wd <= '0;
      end else if (state == S_WAIT) begin
        wd <= wd + 1'b1;
      end
      // Load the sample on entry to ISSUE so it is valid with nn_start
      if (state_d == S_ISSUE) begin
        nn_x1     <= tbl_x1[idx_d];
        nn_x2     <= tbl_x2[idx_d];
        nn_target <= tbl_t[idx_d];
      end
    end
  end

  // Sample table: XOR truth table on reset, writable only while idle
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        tbl_x1[i] <= i[1] ? ONE : '0;
        tbl_x2[i] <= i[0] ? ONE : '0;
        tbl_t[i]  <= (i[1] ^ i[0]) ? ONE : '0;
      end
    end else if (cfg_we && (state == S_IDLE)) begin
      tbl_x1[cfg_addr] <= cfg_x1;
      tbl_x2[cfg_addr] <= cfg_x2;
      tbl_t[cfg_addr]  <= cfg_target;
    end
  end

endmodule
